// File: rtl/render_scheduler.sv
// render_scheduler: master timing and resource scheduler for the render path.
// Owns the pixel/line counters, arbitrates the shared sprite/tile ROM port
// between the sprite engine (A) and the background engine (B) during
// horizontal blanking, swaps the ping-pong line buffers and opens the
// once-per-frame game-logic update window.
module render_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45
) (
  input  logic       pixel_clk,
  input  logic       reset,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       video_active,
  output logic       frame_start,
  output logic       buf_sel,
  output logic [9:0] fetch_line,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       fetch_abort,
  output logic       update_req,
  input  logic       update_done,
  output logic       overrun
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;

  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1_C = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);

  // Round-robin pointer encoding.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  // Increment with wrap back to zero after the given last value.
  function automatic logic [9:0] wrap_inc(input logic [9:0] value,
                                          input logic [9:0] last);
    logic [9:0] result;
    if (value == last) begin
      result = 10'd0;
    end else begin
      result = value + 10'd1;
    end
    return result;
  endfunction

  // Combinational next-state and decode signals.
  logic       h_last_s;
  logic       v_last_s;
  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic [9:0] fetch_next_s;
  logic       active_next_s;
  logic       frame_next_s;
  logic       buf_toggle_s;
  logic       window_open_s;
  logic       window_close_s;
  logic       grant_ok_s;
  logic       pick_a_s;
  logic       upd_start_s;
  logic       upd_end_s;

  // Registered internal state.
  arb_state_t state_r;
  logic       ptr_r;

  // Next-state counter values and everything decoded from them.
  always_comb begin
    h_last_s = (h_count == H_LAST_C);
    v_last_s = (v_count == V_LAST_C);
    h_next_s = wrap_inc(h_count, H_LAST_C);
    if (h_last_s) begin
      v_next_s = wrap_inc(v_count, V_LAST_C);
    end else begin
      v_next_s = v_count;
    end
    fetch_next_s  = wrap_inc(v_next_s, V_LAST_C);
    active_next_s = (h_next_s < H_ACT_C) && (v_next_s < V_ACT_C);
    frame_next_s  = (h_next_s == 10'd0) && (v_next_s == 10'd0);
    // Swap buffers only when the line about to start will be displayed.
    buf_toggle_s  = h_last_s && (v_next_s < V_ACT_C);
    upd_start_s   = (h_next_s == 10'd0) && (v_next_s == V_ACT_C);
    upd_end_s     = h_last_s && v_last_s;
  end

  // Fetch window and arbitration choice for the current cycle.
  always_comb begin
    // The line after the current one must be visible for a prefetch to matter.
    window_open_s  = (h_count >= H_ACT_C) && ((v_count < V_ACT_M1_C) || v_last_s);
    // The next cycle returns to column 0, so any live grant must be revoked now.
    window_close_s = h_last_s;
    // Never start a grant on the closing cycle: it would be visible outside the window.
    grant_ok_s     = window_open_s && !window_close_s;
    if (req_a && req_b) begin
      pick_a_s = (ptr_r == PTR_A);
    end else begin
      pick_a_s = req_a;
    end
  end

  // Pixel/line counters, video decode, prefetch line and buffer select.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_count      <= 10'd0;
      v_count      <= 10'd0;
      video_active <= 1'b0;
      frame_start  <= 1'b0;
      fetch_line   <= 10'd1;
      buf_sel      <= 1'b0;
    end else begin
      h_count      <= h_next_s;
      v_count      <= v_next_s;
      video_active <= active_next_s;
      frame_start  <= frame_next_s;
      fetch_line   <= fetch_next_s;
      if (buf_toggle_s) begin
        buf_sel <= ~buf_sel;
      end else begin
        buf_sel <= buf_sel;
      end
    end
  end

  // ROM port arbiter: one-hot registered grants, round-robin on contention,
  // forced release with an abort pulse when the blanking window closes.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      fetch_abort <= 1'b0;
      ptr_r       <= PTR_A;
    end else begin
      fetch_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_ok_s && (req_a || req_b)) begin
            // The pointer follows the winner so an aborted winner keeps priority.
            if (pick_a_s) begin
              state_r <= GNT_A;
              gnt_a   <= 1'b1;
              gnt_b   <= 1'b0;
              ptr_r   <= PTR_A;
            end else begin
              state_r <= GNT_B;
              gnt_a   <= 1'b0;
              gnt_b   <= 1'b1;
              ptr_r   <= PTR_B;
            end
          end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
          end
        end
        GNT_A: begin
          if (!req_a) begin
            // Transfer complete: hand priority to the other requester.
            state_r <= IDLE;
            gnt_a   <= 1'b0;
            ptr_r   <= PTR_B;
          end else if (window_close_s) begin
            state_r     <= IDLE;
            gnt_a       <= 1'b0;
            fetch_abort <= 1'b1;
          end else begin
            gnt_a <= 1'b1;
          end
          gnt_b <= 1'b0;
        end
        GNT_B: begin
          if (!req_b) begin
            state_r <= IDLE;
            gnt_b   <= 1'b0;
            ptr_r   <= PTR_A;
          end else if (window_close_s) begin
            state_r     <= IDLE;
            gnt_b       <= 1'b0;
            fetch_abort <= 1'b1;
          end else begin
            gnt_b <= 1'b1;
          end
          gnt_a <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
        end
      endcase
    end
  end

  // Game update window: opens entering vertical blanking, closes on done or
  // at the last blank cycle; a window that expires without done is sticky.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      update_req <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (update_req) begin
        // A done arriving on the final cycle still counts as on time.
        if (update_done) begin
          update_req <= 1'b0;
        end else if (upd_end_s) begin
          update_req <= 1'b0;
          overrun    <= 1'b1;
        end else begin
          update_req <= 1'b1;
        end
      end else if (upd_start_s) begin
        update_req <= 1'b1;
      end else begin
        update_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: directed stimulus with a scoreboard of expected
// output events (grant edges, aborts, update window edges, overrun).
module tb_render_scheduler;

  localparam int HA = 16;
  localparam int HB = 8;
  localparam int VA = 6;
  localparam int VB = 3;
  localparam int FRAME = (HA + HB) * (VA + VB);

  // Event codes, listed in the order the monitor scans them each cycle.
  localparam int EV_GA_RISE  = 0;
  localparam int EV_GA_FALL  = 1;
  localparam int EV_GB_RISE  = 2;
  localparam int EV_GB_FALL  = 3;
  localparam int EV_ABORT    = 4;
  localparam int EV_UPD_RISE = 5;
  localparam int EV_UPD_FALL = 6;
  localparam int EV_OVR_RISE = 7;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       video_active;
  logic       frame_start;
  logic       buf_sel;
  logic [9:0] fetch_line;
  logic       req_a;
  logic       req_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       fetch_abort;
  logic       update_req;
  logic       update_done;
  logic       overrun;

  render_scheduler #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .h_count(h_count), .v_count(v_count),
    .video_active(video_active), .frame_start(frame_start),
    .buf_sel(buf_sel), .fetch_line(fetch_line),
    .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .fetch_abort(fetch_abort), .update_req(update_req),
    .update_done(update_done), .overrun(overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int ev;
    int h;
    int v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int ev, input int h, input int v);
    sb_q.push_back('{ev, h, v});
  endtask

  task automatic got_ev(input int ev);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: event %0d at h=%0d v=%0d, expected none",
               ev, h_count, v_count);
    end else begin
      e = sb_q.pop_front();
      if (e.ev != ev || e.h != int'(h_count) || e.v != int'(v_count)) begin
        errors++;
        $display("FAIL sb_event: got ev=%0d h=%0d v=%0d expected ev=%0d h=%0d v=%0d",
                 ev, h_count, v_count, e.ev, e.h, e.v);
      end
    end
  endtask

  // Wait (bounded) for the negedge at which the counters show (h, v).
  task automatic wait_hv(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(h_count) == h && int'(v_count) == v) && n < 1000) begin
      @(negedge pixel_clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_hv: timeout at h=%0d v=%0d waiting for h=%0d v=%0d",
               h_count, v_count, h, v);
    end
  endtask

  // Monitor: detect output events on the falling edge and score them.
  initial begin
    bit pa, pb, pu, po;
    pa = 1'b0; pb = 1'b0; pu = 1'b0; po = 1'b0;
    forever begin
      @(negedge pixel_clk);
      if (gnt_a && !pa)      got_ev(EV_GA_RISE);
      if (!gnt_a && pa)      got_ev(EV_GA_FALL);
      if (gnt_b && !pb)      got_ev(EV_GB_RISE);
      if (!gnt_b && pb)      got_ev(EV_GB_FALL);
      if (fetch_abort)       got_ev(EV_ABORT);
      if (update_req && !pu) got_ev(EV_UPD_RISE);
      if (!update_req && pu) got_ev(EV_UPD_FALL);
      if (overrun && !po)    got_ev(EV_OVR_RISE);
      pa = gnt_a; pb = gnt_b; pu = update_req; po = overrun;
    end
  end

  initial begin
    int fs_cnt, act_cnt, tog_cnt;
    logic prev_buf;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; update_done = 1'b0;

    // Frame 1: update window closed early by done.
    expect_ev(EV_UPD_RISE, 0, 6);  expect_ev(EV_UPD_FALL, 4, 7);
    // Frame 2: arbitration scenarios.
    expect_ev(EV_GA_RISE, 17, 1);  expect_ev(EV_GA_FALL, 21, 1);
    expect_ev(EV_GB_RISE, 17, 2);  expect_ev(EV_GB_FALL, 19, 2);
    expect_ev(EV_GA_RISE, 17, 3);  expect_ev(EV_GA_FALL, 19, 3);
    expect_ev(EV_GB_RISE, 20, 3);
    expect_ev(EV_GB_FALL, 0, 4);   expect_ev(EV_ABORT, 0, 4);
    expect_ev(EV_GB_RISE, 17, 4);  expect_ev(EV_GB_FALL, 21, 4);
    expect_ev(EV_GA_RISE, 22, 4);
    expect_ev(EV_GA_FALL, 0, 5);   expect_ev(EV_ABORT, 0, 5);
    expect_ev(EV_UPD_RISE, 0, 6);  expect_ev(EV_UPD_FALL, 6, 6);
    expect_ev(EV_GA_RISE, 17, 8);  expect_ev(EV_GA_FALL, 20, 8);
    // Frame 3: done on the last window cycle, no overrun.
    expect_ev(EV_UPD_RISE, 0, 6);  expect_ev(EV_UPD_FALL, 0, 0);
    // Frame 4: no done, overrun sets.
    expect_ev(EV_UPD_RISE, 0, 6);  expect_ev(EV_UPD_FALL, 0, 0);
    expect_ev(EV_OVR_RISE, 0, 0);
    // Frame 5: no done again, overrun already set.
    expect_ev(EV_UPD_RISE, 0, 6);  expect_ev(EV_UPD_FALL, 0, 0);
    // Frame 6: grant then asynchronous reset.
    expect_ev(EV_GA_RISE, 17, 1);  expect_ev(EV_GA_FALL, 0, 0);

    repeat (3) @(negedge pixel_clk);
    reset = 1'b0;
    check("rst_h", int'(h_count), 0);
    check("rst_v", int'(v_count), 0);
    check("rst_active", int'(video_active), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_buf_sel", int'(buf_sel), 0);
    check("rst_fetch_line", int'(fetch_line), 1);
    check("rst_gnt", int'({gnt_a, gnt_b}), 0);
    check("rst_flags", int'({fetch_abort, update_req, overrun}), 0);

    // Frame 1 statistics, with update_done pulsed inside the update window.
    fs_cnt = 0; act_cnt = 0; tog_cnt = 0; prev_buf = buf_sel;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge pixel_clk);
      if (i == 0) begin
        check("first_h", int'(h_count), 1);
        check("first_active", int'(video_active), 1);
      end
      if (frame_start) fs_cnt++;
      if (video_active) act_cnt++;
      if (buf_sel != prev_buf) tog_cnt++;
      prev_buf = buf_sel;
      update_done = (int'(h_count) == 3 && int'(v_count) == 7);
    end
    update_done = 1'b0;
    check("frame_start_count", fs_cnt, 1);
    check("video_active_count", act_cnt, HA * VA);
    check("buf_sel_toggles", tog_cnt, VA);
    check("frame2_h", int'(h_count), 0);
    check("frame2_v", int'(v_count), 0);

    // Frame 2.
    wait_hv(5, 1);  req_a = 1'b1;
    check("fetch_line_v1", int'(fetch_line), 2);
    wait_hv(20, 1); req_a = 1'b0;
    wait_hv(5, 2);  update_done = 1'b1;
    @(negedge pixel_clk); update_done = 1'b0;
    wait_hv(16, 2); req_b = 1'b1;
    wait_hv(18, 2); req_b = 1'b0;
    wait_hv(16, 3); req_a = 1'b1; req_b = 1'b1;
    wait_hv(18, 3); req_a = 1'b0;
    wait_hv(10, 4); req_a = 1'b1;
    wait_hv(20, 4); req_b = 1'b0;
    wait_hv(5, 6);  update_done = 1'b1;
    @(negedge pixel_clk); update_done = 1'b0;
    wait_hv(17, 8);
    check("fetch_line_wrap", int'(fetch_line), 0);
    wait_hv(19, 8); req_a = 1'b0;

    // Frame 3.
    wait_hv(0, 0);
    check("overrun_f3", int'(overrun), 0);
    wait_hv(23, 8); update_done = 1'b1;
    @(negedge pixel_clk); update_done = 1'b0;
    check("overrun_f4", int'(overrun), 0);

    // Frames 4 and 5.
    @(negedge pixel_clk);
    wait_hv(0, 0);
    check("overrun_f5", int'(overrun), 1);
    @(negedge pixel_clk);
    wait_hv(0, 0);
    check("overrun_sticky", int'(overrun), 1);

    // Frame 6: reset while gnt_a is high.
    wait_hv(16, 1); req_a = 1'b1;
    wait_hv(20, 1);
    check("pre_reset_gnt_a", int'(gnt_a), 1);
    reset = 1'b1;
    #1;
    check("async_gnt_a", int'(gnt_a), 0);
    check("async_h", int'(h_count), 0);
    check("async_v", int'(v_count), 0);
    check("async_update_req", int'(update_req), 0);
    check("async_overrun", int'(overrun), 0);
    req_a = 1'b0;
    repeat (2) @(negedge pixel_clk);
    reset = 1'b0;
    @(negedge pixel_clk);
    check("release_h", int'(h_count), 1);
    check("release_v", int'(v_count), 0);
    repeat (5) @(negedge pixel_clk);
    check("sb_leftover", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
